alu_nibble_sequencer: RTL and testbench

Multi-cycle controller that performs 16-bit add/subtract/increment/decrement by time-sharing one external combinational 4-bit full adder slice. It processes one nibble per cycle, least-significant first, and chains the carry in a register. It sits between the ALU operand/opcode source (valid/ready handshake) and the 4-bit adder, and it returns the result with carry, zero and signed-overflow flags.

---
 rtl/alu_nibble_if.sv | 39 +++
 rtl/alu_nibble_sequencer.sv | 110 +++++++++++
 tb/tb_alu_nibble_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_nibble_if.sv
// Command, adder-slice and result signals of the nibble-serial ALU sequencer.
// master = command source / result consumer / adder owner, slave = sequencer.
interface alu_nibble_if #(
  parameter int NIB = 4
);
  localparam int W = 4 * NIB;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   in_op;

  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_s;
  logic         add_cout;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic         out_carry;
  logic         out_zero;
  logic         out_ovf;
  logic         busy;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready, add_s, add_cout,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_res,
           out_carry, out_zero, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready, add_s, add_cout,
    output in_ready, add_a, add_b, add_cin, out_valid, out_res,
           out_carry, out_zero, out_ovf, busy
  );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// 16-bit (4*NIB) add/sub/inc/dec built by time-sharing one external 4-bit
// adder slice, one nibble per cycle LSB first, carry chained in a register.
module alu_nibble_sequencer #(
  parameter int NIB = 4
) (
  input logic        clk,
  input logic        rst_n,
  alu_nibble_if.slave bus
);
  localparam int W  = 4 * NIB;
  localparam int KW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Operands as latched at acceptance; B is already in its effective form.
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] be;
  } opnd_t;

  state_t        state_q, state_d;
  opnd_t         opnd_q;
  logic [W-1:0]  res_q;
  logic          carry_q;
  logic [KW-1:0] k_q;

  logic [W-1:0]  be_in;
  logic          c0_in;
  logic          accept;
  logic          last;
  logic          done;

  assign accept = bus.in_valid && (state_q == IDLE);
  assign last   = (k_q == KW'(NIB - 1));
  assign done   = (state_q == DONE);

  // Opcode decode: SUB/INC fold the +1 into the initial carry.
  always_comb begin
    be_in = bus.in_b;
    c0_in = 1'b0;
    case (bus.in_op)
      2'b00: begin be_in = bus.in_b;  c0_in = 1'b0; end
      2'b01: begin be_in = ~bus.in_b; c0_in = 1'b1; end
      2'b10: begin be_in = '0;        c0_in = 1'b1; end
      default: begin be_in = '1;      c0_in = 1'b0; end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake/adder outputs; adder inputs are zero outside RUN.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.add_a     = '0;
    bus.add_b     = '0;
    bus.add_cin   = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        bus.add_a   = opnd_q.a[4*int'(k_q) +: 4];
        bus.add_b   = opnd_q.be[4*int'(k_q) +: 4];
        bus.add_cin = carry_q;
        if (last) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then fold one adder nibble per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
    end else if (accept) begin
      opnd_q.a  <= bus.in_a;
      opnd_q.be <= be_in;
      carry_q   <= c0_in;
      res_q     <= '0;
      k_q       <= '0;
    end else if (state_q == RUN) begin
      res_q[4*int'(k_q) +: 4] <= bus.add_s;
      carry_q                 <= bus.add_cout;
      k_q                     <= last ? '0 : k_q + KW'(1);
    end
  end

  // Flags only assert while a result is presented, so reset/idle read as zero.
  assign bus.out_res   = res_q;
  assign bus.out_carry = done && carry_q;
  assign bus.out_zero  = done && (res_q == '0);
  assign bus.out_ovf   = done && (opnd_q.a[W-1] == opnd_q.be[W-1])
                              && (res_q[W-1] != opnd_q.a[W-1]);
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer with a behavioural 4-bit adder and
// a scoreboard of expected results filled when commands are driven.
module tb_alu_nibble_sequencer;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_nibble_if #(.NIB(NIB)) bus ();

  alu_nibble_sequencer #(.NIB(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External combinational adder slice.
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + 5'(bus.add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] be;
    logic         c0;
    logic [W-1:0] res;
    logic         carry;
    logic         zero;
    logic         ovf;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference of the operation.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    exp_t e;
    logic [W:0] sum;
    e.a  = a;
    e.be = (op == 2'b00) ? b : (op == 2'b01) ? ~b : (op == 2'b10) ? '0 : '1;
    e.c0 = (op == 2'b01) || (op == 2'b10);
    sum  = {1'b0, a} + {1'b0, e.be} + (W+1)'(e.c0);
    e.res   = sum[W-1:0];
    e.carry = sum[W];
    e.zero  = (e.res == '0);
    e.ovf   = (a[W-1] == e.be[W-1]) && (e.res[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  bus.in_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_out_res"},   bus.out_res, 0);
    chk({tag, "_out_carry"}, bus.out_carry, 0);
    chk({tag, "_out_zero"},  bus.out_zero, 0);
    chk({tag, "_out_ovf"},   bus.out_ovf, 0);
    chk({tag, "_add_a"},     bus.add_a, 0);
    chk({tag, "_add_b"},     bus.add_b, 0);
    chk({tag, "_add_cin"},   bus.add_cin, 0);
  endtask

  // Drive a command, push its expectation, return just after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    int cnt;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_valid = 1'b1;
    sb.push_back(model(a, b, op));
    cnt = 0;
    while (!bus.in_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt == 20) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Follow the head command through RUN, hold in DONE `hold` cycles, handshake.
  task automatic collect(input int hold);
    exp_t e;
    int   n;
    bit   got;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e   = sb[0];
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n <= NIB) begin
        chk($sformatf("add_a_k%0d", n-1), bus.add_a, e.a[4*(n-1) +: 4]);
        chk($sformatf("add_b_k%0d", n-1), bus.add_b, e.be[4*(n-1) +: 4]);
        if (n == 1) chk("add_cin_k0", bus.add_cin, e.c0);
      end
      if (bus.out_valid) got = 1'b1;
    end
    chk("latency", n - 1, NIB);
    chk("busy_done", bus.busy, 1);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_res", bus.out_res, e.res);
      chk("hold_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    chk("res",   bus.out_res, e.res);
    chk("carry", bus.out_carry, e.carry);
    chk("zero",  bus.out_zero, e.zero);
    chk("ovf",   bus.out_ovf, e.ovf);
    void'(sb.pop_front());
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("valid_after_hs", bus.out_valid, 0);
    chk("ready_after_hs", bus.in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = 2'b00;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases.
    issue(16'h1234, 16'h0FCD, 2'b00); collect(0);
    issue(16'hFFFF, 16'h0001, 2'b00); collect(0);
    issue(16'h8000, 16'h0001, 2'b01); collect(0);
    issue(16'h7FFF, 16'hABCD, 2'b10); collect(0);
    issue(16'h0000, 16'h5555, 2'b11); collect(0);

    // Backpressure with a second command waiting on in_valid.
    bus.out_ready = 1'b0;
    issue(16'h0005, 16'h0003, 2'b00);
    bus.in_a     = 16'h0009;
    bus.in_b     = 16'h0002;
    bus.in_op    = 2'b01;
    bus.in_valid = 1'b1;
    sb.push_back(model(16'h0009, 16'h0002, 2'b01));
    collect(5);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    collect(0);

    // Asynchronous reset in the middle of RUN.
    issue(16'h1111, 16'h2222, 2'b00);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h0001, 16'h0001, 2'b00); collect(0);

    // Operand/opcode changes after acceptance are ignored.
    issue(16'h5000, 16'h1234, 2'b01);
    bus.in_a  = 16'hFFFF;
    bus.in_b  = 16'h0000;
    bus.in_op = 2'b00;
    collect(0);

    // A few random operations.
    for (int i = 0; i < 4; i++) begin
      issue(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
      collect(0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
